// File: rtl/imm_packer_pkg.sv
// Shared SEXT format codes and small helpers for the immediate packer.
// The encoding matches the SEXT decoder so both sides agree on format numbering.
package imm_packer_pkg;

   typedef enum logic [2:0] {
      SEXT_R    = 3'd0,
      SEXT_I    = 3'd1,
      SEXT_MOVE = 3'd2,
      SEXT_S    = 3'd3,
      SEXT_B    = 3'd4,
      SEXT_U    = 3'd5,
      SEXT_J    = 3'd6
   } sext_op_e;

   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   // True when every bit selected by upper_mask equals the others (a sign run).
   function automatic logic fits_signed(input logic [31:0] v, input logic [31:0] upper_mask);
      return ((v & upper_mask) == 32'h0000_0000) || ((v & upper_mask) == upper_mask);
   endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Request/response bus of the immediate packer: master drives requests, slave is the packer.
interface imm_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] imm;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst;
   logic        err;

   modport master (
      output in_valid, op, imm, base, out_ready,
      input  in_ready, out_valid, inst, err
   );

   modport slave (
      input  in_valid, op, imm, base, out_ready,
      output in_ready, out_valid, inst, err
   );
endinterface

// File: rtl/imm_scatter.sv
// Combinational per-format immediate scatter into a base instruction word.
// Range checking of the immediate is present only when IMM_RANGE_CHECK_EN is defined.
module imm_scatter
   import imm_packer_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic [31:0] inst,
   output logic        err
);

   logic op_ill_s;
   logic range_err_s;

   // Bit scatter; positions not owned by the format keep the base value.
   always_comb begin
      inst     = base;
      op_ill_s = 1'b0;
      case (sext_op_e'(op))
         SEXT_R:    inst = base;
         SEXT_I:    inst[31:20] = imm[11:0];
         SEXT_MOVE: inst[24:20] = imm[4:0];
         SEXT_S: begin
            inst[31:25] = imm[11:5];
            inst[11:7]  = imm[4:0];
         end
         SEXT_B: begin
            inst[31]    = imm[12];
            inst[7]     = imm[11];
            inst[30:25] = imm[10:5];
            inst[11:8]  = imm[4:1];
         end
         SEXT_U:    inst[31:12] = imm[31:12];
         SEXT_J: begin
            inst[31]    = imm[20];
            inst[30:21] = imm[10:1];
            inst[20]    = imm[11];
            inst[19:12] = imm[19:12];
         end
         default: begin
            inst     = base;
            op_ill_s = 1'b1;
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // Flags immediates whose value would be lost by the truncating scatter.
   always_comb begin
      range_err_s = 1'b0;
      case (sext_op_e'(op))
         SEXT_I, SEXT_S: range_err_s = !fits_signed(imm, 32'hFFFF_F800);
         SEXT_B:         range_err_s = imm[0] || !fits_signed(imm, 32'hFFFF_F000);
         SEXT_J:         range_err_s = imm[0] || !fits_signed(imm, 32'hFFF0_0000);
         SEXT_U:         range_err_s = (imm[11:0] != 12'h000);
         SEXT_MOVE:      range_err_s = (imm[31:5] != 27'h0);
         default:        range_err_s = 1'b0;
      endcase
   end
`else
   assign range_err_s = 1'b0;
`endif

   assign err = op_ill_s | range_err_s;

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate packer with a saturating error counter.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_packer
   import imm_packer_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imm_packer_if.slave          bus,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_cnt_clr
);

   logic                 s1_valid_r;
   logic [31:0]          s1_inst_r;
   logic                 s1_err_r;
   logic                 out_valid_r;
   logic [31:0]          inst_r;
   logic                 err_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;
   logic [ERR_CNT_W-1:0] err_cnt_nxt_s;
   logic [31:0]          pack_inst_s;
   logic                 pack_err_s;
   logic                 s1_ready_s;
   logic                 s2_ready_s;
   logic                 in_xfer_s;
   logic                 out_xfer_s;

   imm_scatter u_scatter (
      .op   (bus.op),
      .imm  (bus.imm),
      .base (bus.base),
      .inst (pack_inst_s),
      .err  (pack_err_s)
   );

   assign s2_ready_s = !out_valid_r || bus.out_ready;
   assign s1_ready_s = !s1_valid_r || s2_ready_s;
   assign in_xfer_s  = bus.in_valid && s1_ready_s;
   assign out_xfer_s = out_valid_r && bus.out_ready;

   // Stage 1 register: captures the packed word whenever it can move forward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_inst_r  <= 32'h0000_0000;
         s1_err_r   <= 1'b0;
      end else if (s1_ready_s) begin
         s1_valid_r <= bus.in_valid;
         if (in_xfer_s) begin
            s1_inst_r <= pack_inst_s;
            s1_err_r  <= pack_err_s;
         end
      end
   end

   // Stage 2 register: output holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         inst_r      <= 32'h0000_0000;
         err_r       <= 1'b0;
      end else if (s2_ready_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            inst_r <= s1_inst_r;
            err_r  <= s1_err_r;
         end
      end
   end

   // Error counter next value; clear wins over a same-cycle increment.
   always_comb begin
      err_cnt_nxt_s = err_cnt_r;
      if (err_cnt_clr) begin
         err_cnt_nxt_s = {ERR_CNT_W{1'b0}};
      end else if (out_xfer_s && err_r && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
         err_cnt_nxt_s = err_cnt_r + ERR_CNT_W'(1);
      end else begin
         err_cnt_nxt_s = err_cnt_r;
      end
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else begin
         err_cnt_r <= err_cnt_nxt_s;
      end
   end

   assign bus.in_ready  = s1_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.inst      = inst_r;
   assign bus.err       = err_r;
   assign err_cnt       = err_cnt_r;

endmodule
